// File: rtl/checkpoint_seq_monitor.sv
// Watches a status bus for a programmed, ordered sequence of checkpoint codes.
// Glitch-filtered sampling, per-step timeout, pass/mismatch/timeout reporting.
module checkpoint_seq_monitor #(
  parameter int DATA_W        = 16,
  parameter int DEPTH         = 8,
  parameter int TIMEOUT_W     = 24,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [DATA_W-1:0]        obs_data,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [DATA_W-1:0]        cfg_data,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic                     cfg_strict,
  input  logic [TIMEOUT_W-1:0]     timeout_lim,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     fail_mismatch,
  output logic                     fail_timeout,
  output logic                     match,
  output logic [$clog2(DEPTH):0]   step_idx,
  output logic [DATA_W-1:0]        err_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PASS,
    S_FAIL,
    S_TMO
  } state_t;

  state_t                state;
  logic [DATA_W-1:0]     table_mem [DEPTH];
  logic [DATA_W-1:0]     last_sample;
  logic [DATA_W-1:0]     last_qual;
  logic [RW-1:0]         run_cnt;
  logic [RW-1:0]         run_next;
  logic                  same;
  logic                  qual;
  logic [TIMEOUT_W-1:0]  tmo_cnt;
  logic [TIMEOUT_W-1:0]  tmo_inc;
  logic [TIMEOUT_W-1:0]  lim_q;
  logic [AW:0]           len_q;
  logic                  strict_q;
  logic [AW:0]           step_inc;
  logic [DATA_W-1:0]     exp_code;

  // run_cnt==0 only straight after reset, meaning "no previous sample".
  always_comb begin
    same = (run_cnt != '0) && (obs_data == last_sample);
    if (!same)
      run_next = RW'(1);
    else if (run_cnt == RW'(STABLE_CYCLES))
      run_next = run_cnt;
    else
      run_next = run_cnt + 1'b1;
    qual = (run_next == RW'(STABLE_CYCLES)) &&
           ((run_cnt != RW'(STABLE_CYCLES)) || !same);
  end

  assign tmo_inc  = tmo_cnt + 1'b1;
  assign step_inc = step_idx + 1'b1;
  assign exp_code = table_mem[step_idx[AW-1:0]];

  always_ff @(posedge ap_clk) begin
    if (cfg_we && state != S_WAIT)
      table_mem[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      run_cnt     <= '0;
      last_sample <= '0;
      last_qual   <= '0;
    end else begin
      run_cnt     <= run_next;
      last_sample <= obs_data;
      if (qual)
        last_qual <= obs_data;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_mismatch <= 1'b0;
      fail_timeout  <= 1'b0;
      match         <= 1'b0;
      step_idx      <= '0;
      err_data      <= '0;
      tmo_cnt       <= '0;
      lim_q         <= '0;
      len_q         <= '0;
      strict_q      <= 1'b0;
    end else begin
      match <= 1'b0;
      if (abort) begin
        state         <= S_IDLE;
        busy          <= 1'b0;
        done          <= 1'b0;
        pass          <= 1'b0;
        fail_mismatch <= 1'b0;
        fail_timeout  <= 1'b0;
        step_idx      <= '0;
        err_data      <= '0;
        tmo_cnt       <= '0;
      end else begin
        case (state)
          S_WAIT: begin
            // Priority inside WAIT: match > strict mismatch > timeout.
            if (qual && obs_data == exp_code) begin
              match    <= 1'b1;
              step_idx <= step_inc;
              tmo_cnt  <= '0;
              if (step_inc == len_q) begin
                state <= S_PASS;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
              end
            end else if (qual && strict_q) begin
              state         <= S_FAIL;
              busy          <= 1'b0;
              done          <= 1'b1;
              fail_mismatch <= 1'b1;
              err_data      <= obs_data;
            end else if (lim_q != '0 && tmo_inc == lim_q) begin
              state        <= S_TMO;
              busy         <= 1'b0;
              done         <= 1'b1;
              fail_timeout <= 1'b1;
              err_data     <= qual ? obs_data : last_qual;
            end else begin
              tmo_cnt <= tmo_inc;
            end
          end
          default: begin
            if (start) begin
              lim_q         <= timeout_lim;
              len_q         <= cfg_len;
              strict_q      <= cfg_strict;
              step_idx      <= '0;
              tmo_cnt       <= '0;
              err_data      <= '0;
              fail_mismatch <= 1'b0;
              fail_timeout  <= 1'b0;
              if (cfg_len == '0) begin
                state <= S_PASS;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b1;
              end else begin
                state <= S_WAIT;
                busy  <= 1'b1;
                done  <= 1'b0;
                pass  <= 1'b0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule
